sumsq_serial: RTL and testbench
===============================

# sumsq_serial

Sequential sum-of-squares unit that accepts an (X, Y) operand pair over a valid/ready handshake. It computes X² + Y² with a single shift-add datapath over 2·W cycles and presents the result on a valid/ready output. It sits directly upstream of the hypotenuse square-root stage and replaces a wide parallel multiplier with one adder and a counter.

## Interface
- W, default 8: operand width; result width is 2·W+1.
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept an operand pair; high only in IDLE.
- x_in  input  W  X operand, unsigned.
- y_in  input  W  Y operand, unsigned.
- out_valid  output  1  result present; high only in DONE.
- out_ready  input  1  downstream accepts the result.
- sum_sq  output  2·W+1  X² + Y², unsigned.
- busy  output  1  high in MUL_X, MUL_Y or DONE.

## Operation
- States: IDLE, MUL_X, MUL_Y, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture x_in/y_in into internal registers.
  - Clear the accumulator and the bit counter, then go to MUL_X.
- MUL_X: each cycle, if x_reg[cnt]=1 then acc += x_reg << cnt. cnt increments. When cnt=W-1, reset cnt to 0 and go to MUL_Y.
- MUL_Y: same as MUL_X using y_reg. When cnt=W-1, go to DONE.
- DONE:
  - out_valid=1 and sum_sq=acc.
  - On out_valid&&out_ready, go to IDLE.
- Accumulator width is 2·W+1, so the result is exact with no wrap. Max for W=8: 255²+255² = 130050 (17'h1FC02).
- in_valid is ignored outside IDLE. x_in/y_in are sampled only on the accepting edge.
- No bypass: in_ready cannot rise in the same cycle as the output handshake.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, in_ready=1, out_valid=0, busy=0, sum_sq=0, acc=0, cnt=0.
- Reset mid-operation in any state aborts the pending pair with no output. The block resumes in IDLE with in_ready=1.
- Latency:
  - Input acceptance edge E0 is followed by 2·W edges of computation.
  - out_valid rises after edge E0+2·W (16 cycles for W=8).
- sum_sq and out_valid hold stable while out_valid&&!out_ready, for any number of cycles.
- With in_valid and out_ready tied high, a new pair is accepted every 2·W+2 cycles (18 for W=8).
- in_ready and out_valid are decoded from registered state only, with no combinational path from in_valid or out_ready.
- sum_sq keeps its last value outside DONE. It is guaranteed meaningful only while out_valid=1.

## Configuration
- SUMSQ_SAT_EN:
  - Defined: if the exact sum is ≥ 2^(2·W), the output is clamped. sum_sq[2·W-1:0] is all-ones and sum_sq[2·W] is 0. Otherwise the output is the exact sum with bit 2·W = 0. This allows direct connection to a 2·W-bit square-root stage.
  - Not defined: sum_sq carries the full exact 2·W+1-bit sum.
- Timing and handshake behaviour are identical in both builds.

## Test plan
- Basic: after reset, send x=3, y=4 with out_ready=1. Expect in_ready=0 next cycle, out_valid high after exactly 16 edges, sum_sq=25, and in_ready=1 the cycle after the handshake.
- Maximum value: send x=255, y=255.
  - Without macro: sum_sq=130050.
  - With SUMSQ_SAT_EN: sum_sq=65535.
- Boundary values:
  - x=181, y=181 gives 65522 in both builds, with no clamp.
  - x=0, y=0 gives 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises. Expect sum_sq and out_valid stable, and in_ready=0 throughout. Changing x_in/y_in during computation does not alter the result.
- Throughput: tie in_valid and out_ready high and stream 4 pairs. Expect results 18 cycles apart, in input order, with correct values.
- Reset mid-operation: assert rst_n=0 during MUL_Y. Expect out_valid=0, busy=0, sum_sq=0 immediately, in_ready=1 after release, and a following pair (6, 8) yields 100.

Source files
------------

// File: rtl/sumsq_serial_if.sv
// Operand/result handshake bundle for sumsq_serial.
// The DUT connects through the slave modport; an upstream driver uses master.
interface sumsq_serial_if #(
   parameter int W = 8
);
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   x_in;
   logic [W-1:0]   y_in;
   logic           out_valid;
   logic           out_ready;
   logic [2*W:0]   sum_sq;

   modport master (
      output in_valid, x_in, y_in, out_ready,
      input  in_ready, out_valid, sum_sq
   );

   modport slave (
      input  in_valid, x_in, y_in, out_ready,
      output in_ready, out_valid, sum_sq
   );
endinterface

// File: rtl/sumsq_serial.sv
// Serial shift-add X^2 + Y^2 over 2*W cycles.
// Optional SUMSQ_SAT_EN clamps the result to 2*W bits of all-ones on overflow.
module sumsq_serial #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   sumsq_serial_if.slave  bus,
   output logic           busy
);

   localparam int ACC_W = 2 * W + 1;
   localparam int CW    = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   typedef enum logic [1:0] {IDLE, MUL_X, MUL_Y, DONE} state_t;

   state_t             state_q, state_d;
   logic [W-1:0]       x_q, x_d;
   logic [W-1:0]       y_q, y_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [ACC_W-1:0]   sum_sq_q, sum_sq_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         sum_sq_q <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         sum_sq_q <= sum_sq_d;
      end
   end

   // sum_sq is registered on entry to DONE so it holds its value in every other state
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      sum_sq_d = sum_sq_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               x_d     = bus.x_in;
               y_d     = bus.y_in;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = MUL_X;
            end
         end
         MUL_X: begin
            if (x_q[cnt_q]) acc_d = acc_q + (ACC_W'(x_q) << cnt_q);
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = MUL_Y;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         MUL_Y: begin
            if (y_q[cnt_q]) acc_d = acc_q + (ACC_W'(y_q) << cnt_q);
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = DONE;
`ifdef SUMSQ_SAT_EN
               if (acc_d[ACC_W-1]) sum_sq_d = {1'b0, {(2*W){1'b1}}};
               else                sum_sq_d = acc_d;
`else
               sum_sq_d = acc_d;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.sum_sq    = sum_sq_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_sumsq_serial.sv
// Directed self-checking bench for sumsq_serial (W=8), valid in both SUMSQ_SAT_EN builds.
module tb_sumsq_serial;

   localparam int W = 8;

   logic clk;
   logic rst_n;
   logic busy;
   int   checks;
   int   errors;
   int   cyc;

   sumsq_serial_if #(.W(W)) bus ();

   sumsq_serial #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one pair through the accepting edge, then scrambles the inputs
   task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y);
      checkOutput("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
      bus.x_in     = x;
      bus.y_in     = y;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.x_in     = ~x;
      bus.y_in     = ~y;
      checkOutput("in_ready_after_accept", 32'(bus.in_ready), 32'd0);
      checkOutput("busy_after_accept", 32'(busy), 32'd1);
   endtask

   task automatic waitResult(output int edges);
      edges = 0;
      while (!bus.out_valid && edges < 100) begin
         tick();
         edges++;
      end
   endtask

   task automatic runPair(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [31:0] exp);
      int edges;
      bus.out_ready = 1'b1;
      applyStimulus(x, y);
      waitResult(edges);
      checkOutput({tag, "_latency"}, 32'(edges), 32'd16);
      checkOutput({tag, "_sum"}, 32'(bus.sum_sq), exp);
      tick();
      checkOutput({tag, "_out_valid_drop"}, 32'(bus.out_valid), 32'd0);
      checkOutput({tag, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      int edges;
      int prev_cyc;
      logic [W-1:0] px [4];
      logic [W-1:0] py [4];
      logic [31:0]  pe [4];

      checks        = 0;
      errors        = 0;
      cyc           = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.x_in      = '0;
      bus.y_in      = '0;
      bus.out_ready = 1'b1;

      #1;
      checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_sum_sq", 32'(bus.sum_sq), 32'd0);
      #12 rst_n = 1'b1;
      tick();

      runPair("basic_3_4", 8'd3, 8'd4, 32'd25);
`ifdef SUMSQ_SAT_EN
      runPair("max_255_255", 8'd255, 8'd255, 32'd65535);
`else
      runPair("max_255_255", 8'd255, 8'd255, 32'd130050);
`endif
      runPair("edge_181_181", 8'd181, 8'd181, 32'd65522);
      runPair("zero_0_0", 8'd0, 8'd0, 32'd0);

      // Backpressure: result and handshake must hold while downstream stalls
      bus.out_ready = 1'b0;
      applyStimulus(8'd12, 8'd5);
      waitResult(edges);
      checkOutput("bp_latency", 32'(edges), 32'd16);
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_out_valid_hold", 32'(bus.out_valid), 32'd1);
         checkOutput("bp_sum_hold", 32'(bus.sum_sq), 32'd169);
         checkOutput("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      checkOutput("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("bp_release_in_ready", 32'(bus.in_ready), 32'd1);

      // Streaming with in_valid and out_ready tied high
      px[0] = 8'd1;   py[0] = 8'd2;   pe[0] = 32'd5;
      px[1] = 8'd10;  py[1] = 8'd20;  pe[1] = 32'd500;
      px[2] = 8'd100; py[2] = 8'd50;  pe[2] = 32'd12500;
      px[3] = 8'd7;   py[3] = 8'd0;   pe[3] = 32'd49;
      prev_cyc     = 0;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.x_in = px[k];
         bus.y_in = py[k];
         tick();
         bus.x_in = 8'hAA;
         bus.y_in = 8'h55;
         waitResult(edges);
         checkOutput("stream_latency", 32'(edges), 32'd16);
         checkOutput("stream_sum", 32'(bus.sum_sq), pe[k]);
         if (k > 0) checkOutput("stream_spacing", 32'(cyc - prev_cyc), 32'd18);
         prev_cyc = cyc;
         tick();
      end
      bus.in_valid = 1'b0;
      tick();

      // Reset during MUL_Y aborts the pair without output
      applyStimulus(8'd200, 8'd100);
      for (int i = 0; i < 11; i++) tick();
      checkOutput("midrst_busy_before", 32'(busy), 32'd1);
      checkOutput("midrst_out_valid_before", 32'(bus.out_valid), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_sum_sq", 32'(bus.sum_sq), 32'd0);
      #2 rst_n = 1'b1;
      tick();
      checkOutput("midrst_in_ready_after", 32'(bus.in_ready), 32'd1);
      runPair("after_rst_6_8", 8'd6, 8'd8, 32'd100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
